// File: rtl/vedic_mult_pipe_if.sv
// Operand/result handshake bundle for vedic_mult_pipe: valid/ready input side carrying
// operands, mode and tag; valid/ready output side carrying product and tag.
interface vedic_mult_pipe_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_signed;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_prod;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      input  in_ready, out_valid, out_prod, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      output in_ready, out_valid, out_prod, out_tag
   );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier: sign/magnitude split, four recursive
// half-width Vedic products, then combine and re-apply sign. Global stall on out_ready.

// Recursive N x N Vedic multiplier, bottoming out in a 2x2 gate-level cell.
module vedic_mult_pipe_core #(
   parameter int N = 2
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);
   generate
      if (N == 2) begin : g_cell
         logic cross_a;
         logic cross_b;
         logic high;
         logic carry;
         assign cross_a = a[1] & b[0];
         assign cross_b = a[0] & b[1];
         assign high    = a[1] & b[1];
         assign carry   = cross_a & cross_b;
         assign p = {high & carry, high ^ carry, cross_a ^ cross_b, a[0] & b[0]};
      end else begin : g_split
         localparam int H = N / 2;
         // pp[0]=aL*bL, pp[1]=aH*bL, pp[2]=aL*bH, pp[3]=aH*bH
         logic [N-1:0] pp [4];
         logic [N:0]   mid;
         for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            vedic_mult_pipe_core #(.N(H)) u_sub (
               .a (a[(gi % 2) * H +: H]),
               .b (b[(gi / 2) * H +: H]),
               .p (pp[gi])
            );
         end
         assign mid = {1'b0, pp[1]} + {1'b0, pp[2]};
         // The full product is below 2^(2N), so the 2N-bit sum never drops a carry.
         assign p = {pp[3], pp[0]} + ({{(N-1){1'b0}}, mid} << H);
      end
   endgenerate
endmodule

module vedic_mult_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   vedic_mult_pipe_if.slave bus
);
   localparam int H  = WIDTH / 2;
   localparam int PW = 2 * WIDTH;

   generate
      if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
         $error("vedic_mult_pipe: WIDTH must be a power of two in 4..32");
      end
      if (TAG_W < 1) begin : g_bad_tag
         $error("vedic_mult_pipe: TAG_W must be at least 1");
      end
   endgenerate

   logic               adv;

   logic               s1_valid_reg;
   logic [TAG_W-1:0]   s1_tag_reg;
   logic [WIDTH-1:0]   s1_a_reg;
   logic [WIDTH-1:0]   s1_b_reg;
   logic               s1_neg_reg;

   logic               s2_valid_reg;
   logic [TAG_W-1:0]   s2_tag_reg;
   logic               s2_neg_reg;
   logic [WIDTH-1:0]   s2_pp_reg [4];

   logic               s3_valid_reg;
   logic [TAG_W-1:0]   s3_tag_reg;
   logic [PW-1:0]      s3_prod_reg;

   logic [WIDTH-1:0]   a_mag_next;
   logic [WIDTH-1:0]   b_mag_next;
   logic               neg_next;
   logic [WIDTH-1:0]   pp_next [4];
   logic [WIDTH:0]     mid_sum;
   logic [PW-1:0]      prod_mag;
   logic [PW-1:0]      prod_next;

   assign adv          = bus.out_ready || !s3_valid_reg;
   assign bus.in_ready = adv;
   assign bus.out_valid = s3_valid_reg;
   assign bus.out_prod  = s3_prod_reg;
   assign bus.out_tag   = s3_tag_reg;

   // Magnitude of the most negative value is 2^(WIDTH-1), still representable unsigned.
   assign a_mag_next = (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
   assign b_mag_next = (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
   assign neg_next   = bus.in_signed && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_pp
         vedic_mult_pipe_core #(.N(H)) u_core (
            .a (s1_a_reg[(gi % 2) * H +: H]),
            .b (s1_b_reg[(gi / 2) * H +: H]),
            .p (pp_next[gi])
         );
      end
   endgenerate

   assign mid_sum   = {1'b0, s2_pp_reg[1]} + {1'b0, s2_pp_reg[2]};
   assign prod_mag  = {s2_pp_reg[3], s2_pp_reg[0]} + ({{(WIDTH-1){1'b0}}, mid_sum} << H);
   assign prod_next = s2_neg_reg ? -prod_mag : prod_mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_tag_reg   <= '0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_neg_reg   <= 1'b0;
         s2_valid_reg <= 1'b0;
         s2_tag_reg   <= '0;
         s2_neg_reg   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            s2_pp_reg[i] <= '0;
         end
         s3_valid_reg <= 1'b0;
         s3_tag_reg   <= '0;
         s3_prod_reg  <= '0;
      end else if (adv) begin
         s1_valid_reg <= bus.in_valid;
         s1_tag_reg   <= bus.in_tag;
         s1_a_reg     <= a_mag_next;
         s1_b_reg     <= b_mag_next;
         s1_neg_reg   <= neg_next;
         s2_valid_reg <= s1_valid_reg;
         s2_tag_reg   <= s1_tag_reg;
         s2_neg_reg   <= s1_neg_reg;
         for (int i = 0; i < 4; i++) begin
            s2_pp_reg[i] <= pp_next[i];
         end
         s3_valid_reg <= s2_valid_reg;
         s3_tag_reg   <= s2_tag_reg;
         s3_prod_reg  <= prod_next;
      end
   end
endmodule
